// File: rtl/sobel_pkg.sv
// Shared widths, pipeline depth and kernel weights for the Sobel edge path.
package sobel_pkg;

    localparam int PIX_W         = 8;
    localparam int GRAD_W        = 11;
    localparam int MAG_W         = 11;
    localparam int SOBEL_LATENCY = 3;

    localparam logic signed [GRAD_W-1:0] K_W0 = 11'sd1;
    localparam logic signed [GRAD_W-1:0] K_W1 = 11'sd2;
    localparam logic signed [GRAD_W-1:0] K_W2 = 11'sd1;

    typedef struct packed {
        logic valid;
        logic hsync;
        logic vsync;
    } sync_t;

    // One 1-2-1 weighted tap sum of three pixels along a row or column.
    function automatic logic signed [GRAD_W-1:0] wsum(
        input logic [PIX_W-1:0] a,
        input logic [PIX_W-1:0] b,
        input logic [PIX_W-1:0] c
    );
        logic signed [GRAD_W-1:0] ea;
        logic signed [GRAD_W-1:0] eb;
        logic signed [GRAD_W-1:0] ec;
        ea = signed'({{(GRAD_W-PIX_W){1'b0}}, a});
        eb = signed'({{(GRAD_W-PIX_W){1'b0}}, b});
        ec = signed'({{(GRAD_W-PIX_W){1'b0}}, c});
        return ea * K_W0 + eb * K_W1 + ec * K_W2;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One video line of pixel storage: simple dual-port RAM, old data read
// combinationally at the address being written (read-before-write).
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_pixel,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [PIX_W-1:0] i_wdata,
    output logic [PIX_W-1:0] o_rdata
);

    logic [PIX_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_pixel) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/sobel_edge_detect.sv
// Streaming 3x3 Sobel edge detector: line buffers + window, gradients,
// thresholded magnitude, with matched sync/valid delay.
module sobel_edge_detect
    import sobel_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int LATENCY  = SOBEL_LATENCY
) (
    input  logic             clk_pixel,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_hsync,
    input  logic             in_vsync,
    input  logic [PIX_W-1:0] in_gray,
    input  logic [MAG_W-1:0] threshold,
    output logic             valid,
    output logic             hsync,
    output logic             vsync,
    output logic             sobel
);

    localparam int CW = $clog2(H_ACTIVE + 1);
    localparam int AW = $clog2(H_ACTIVE);

    logic [CW-1:0]           r_col;
    logic [1:0]              r_row;
    logic                    r_hs_prev;
    logic                    r_vs_prev;
    logic                    r_armed;
    logic [MAG_W-1:0]        r_thr;
    logic [PIX_W-1:0]        r_win [3][3];
    logic                    r_s1_ok;
    logic                    r_s2_ok;
    logic signed [GRAD_W-1:0] r_gx;
    logic signed [GRAD_W-1:0] r_gy;
    logic                    r_sobel;
    sync_t                   r_dly [LATENCY];

    logic             w_in_line;
    logic             w_we;
    logic             w_vs_rise;
    logic [AW-1:0]    w_addr;
    logic [PIX_W-1:0] w_lb1;
    logic [PIX_W-1:0] w_lb2;
    logic [MAG_W-1:0] w_ax;
    logic [MAG_W-1:0] w_ay;
    logic [MAG_W-1:0] w_mag;

    assign w_in_line = r_col < CW'(H_ACTIVE);
    assign w_we      = in_valid && w_in_line;
    assign w_vs_rise = in_vsync && !r_vs_prev;
    assign w_addr    = r_col[AW-1:0];

    sobel_line_buffer #(.DEPTH(H_ACTIVE), .AW(AW)) u_lb1 (
        .clk_pixel (clk_pixel),
        .i_we      (w_we),
        .i_addr    (w_addr),
        .i_wdata   (in_gray),
        .o_rdata   (w_lb1)
    );

    sobel_line_buffer #(.DEPTH(H_ACTIVE), .AW(AW)) u_lb2 (
        .clk_pixel (clk_pixel),
        .i_we      (w_we),
        .i_addr    (w_addr),
        .i_wdata   (w_lb1),
        .o_rdata   (w_lb2)
    );

    // r_vs_prev resets high so releasing reset mid-frame is not a frame start.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_col     <= '0;
            r_row     <= '0;
            r_hs_prev <= 1'b0;
            r_vs_prev <= 1'b1;
            r_armed   <= 1'b0;
            r_thr     <= 11'h7FF;
        end else begin
            r_hs_prev <= in_hsync;
            r_vs_prev <= in_vsync;
            if (!in_hsync) r_col <= '0;
            else if (w_we) r_col <= r_col + 1'b1;
            if (!in_vsync) r_row <= '0;
            else if (!in_hsync && r_hs_prev && r_row != 2'd3) r_row <= r_row + 1'b1;
            if (w_vs_rise) begin
                r_thr   <= threshold;
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    r_win[r][c] <= '0;
            r_s1_ok <= 1'b0;
        end else begin
            if (in_valid) begin
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= w_lb2;
                r_win[1][2] <= w_lb1;
                r_win[2][2] <= in_gray;
            end
            r_s1_ok <= w_we && r_row[1] && (r_col >= CW'(2)) && r_armed;
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_gx    <= '0;
            r_gy    <= '0;
            r_s2_ok <= 1'b0;
        end else begin
            r_gx <= wsum(r_win[0][2], r_win[1][2], r_win[2][2])
                  - wsum(r_win[0][0], r_win[1][0], r_win[2][0]);
            r_gy <= wsum(r_win[2][0], r_win[2][1], r_win[2][2])
                  - wsum(r_win[0][0], r_win[0][1], r_win[0][2]);
            r_s2_ok <= r_s1_ok;
        end
    end

    assign w_ax  = r_gx[GRAD_W-1] ? unsigned'(-r_gx) : unsigned'(r_gx);
    assign w_ay  = r_gy[GRAD_W-1] ? unsigned'(-r_gy) : unsigned'(r_gy);
    assign w_mag = w_ax + w_ay;

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_sobel <= 1'b0;
            for (int i = 0; i < LATENCY; i++) r_dly[i] <= '0;
        end else begin
            r_sobel  <= r_s2_ok && (w_mag > r_thr);
            r_dly[0] <= '{valid: in_valid, hsync: in_hsync, vsync: in_vsync};
            for (int i = 1; i < LATENCY; i++) r_dly[i] <= r_dly[i-1];
        end
    end

    assign valid = r_dly[LATENCY-1].valid;
    assign hsync = r_dly[LATENCY-1].hsync;
    assign vsync = r_dly[LATENCY-1].vsync;
    assign sobel = r_sobel;

endmodule

// File: tb/tb_sobel_edge_detect.sv
// Scoreboard bench for sobel_edge_detect: directed frames, expected outputs
// queued at drive time and checked LATENCY cycles later by a monitor.
module tb_sobel_edge_detect;

    localparam int H   = 16;
    localparam int LAT = 3;

    logic        clk_pixel = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_hsync  = 1'b0;
    logic        in_vsync  = 1'b0;
    logic [7:0]  in_gray   = '0;
    logic [10:0] threshold = '0;
    logic        valid;
    logic        hsync;
    logic        vsync;
    logic        sobel;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int   stamp;
        logic ev;
        logic eh;
        logic evs;
        logic es;
    } exp_t;

    exp_t q[$];

    sobel_edge_detect #(.H_ACTIVE(H), .LATENCY(LAT)) dut (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_hsync  (in_hsync),
        .in_vsync  (in_vsync),
        .in_gray   (in_gray),
        .threshold (threshold),
        .valid     (valid),
        .hsync     (hsync),
        .vsync     (vsync),
        .sobel     (sobel)
    );

    always #5 clk_pixel = ~clk_pixel;

    always @(posedge clk_pixel) cyc <= cyc + 1;

    function automatic logic [7:0] pix(int kind, int r, int c);
        case (kind)
            0:       return 8'd100;
            1:       return (c >= 8 && c < 16) ? 8'd255 : 8'd0;
            default: return (r < 2) ? 8'd0 : 8'd200;
        endcase
    endfunction

    // Hand-derived edge locations: vertical edge mag 1020, horizontal 800.
    function automatic logic hit(int kind, int r, int c);
        case (kind)
            1:       return (r >= 2) && (c == 8 || c == 9);
            2:       return (r >= 2) && (c >= 2) && (c < 16);
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(logic v, logic h, logic vs, logic [7:0] g, logic s);
        @(negedge clk_pixel);
        in_valid = v;
        in_hsync = h;
        in_vsync = vs;
        in_gray  = g;
        q.push_back('{stamp: cyc, ev: v, eh: h, evs: vs, es: s});
    endtask

    task automatic check_zero(string tag);
        n_tests++;
        if ({valid, hsync, vsync, sobel} !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s: v/h/vs/s got %b%b%b%b want 0000",
                     tag, valid, hsync, vsync, sobel);
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk_pixel);
        rst_n = 1'b0;
        q.delete();
        #1 check_zero("async_reset");
        q.push_back('{stamp: cyc, ev: 1'b0, eh: 1'b0, evs: 1'b0, es: 1'b0});
        @(negedge clk_pixel);
        q.push_back('{stamp: cyc, ev: 1'b0, eh: 1'b0, evs: 1'b0, es: 1'b0});
        @(negedge clk_pixel);
        rst_n = 1'b1;
        q.push_back('{stamp: cyc, ev: in_valid, eh: in_hsync,
                      evs: in_vsync, es: 1'b0});
    endtask

    task automatic frame(int kind, int long_row, logic on, int mid_thr, bit do_rst);
        logic en;
        en = on;
        repeat (3) drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            int len;
            len = (r == long_row) ? 20 : 16;
            if (r == 1 && mid_thr >= 0) threshold = 11'(mid_thr);
            for (int c = 0; c < len; c++) begin
                if (c == 4) drive(1'b0, 1'b1, 1'b1, 8'd0, 1'b0);
                drive(1'b1, 1'b1, 1'b1, pix(kind, r, c), en && hit(kind, r, c));
                if (do_rst && r == 2 && c == 5) begin
                    reset_pulse();
                    en = 1'b0;
                end
            end
            repeat (3) drive(1'b0, 1'b0, 1'b1, 8'd0, 1'b0);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_pixel);
            #1;
            while (q.size() > 0 && q[0].stamp + LAT <= cyc) begin
                e = q.pop_front();
                n_tests++;
                if (e.stamp + LAT != cyc ||
                    {valid, hsync, vsync, sobel} !== {e.ev, e.eh, e.evs, e.es}) begin
                    n_fail++;
                    $display("FAIL out@cyc%0d (in@%0d): v/h/vs/s got %b%b%b%b want %b%b%b%b",
                             cyc, e.stamp, valid, hsync, vsync, sobel,
                             e.ev, e.eh, e.evs, e.es);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        threshold = 11'd50;
        repeat (3) @(negedge clk_pixel);
        check_zero("reset_state");
        @(negedge clk_pixel);
        rst_n = 1'b1;

        frame(0, -1, 1'b0, -1, 1'b0);
        threshold = 11'd100;
        frame(1, -1, 1'b1, -1, 1'b0);
        frame(2, -1, 1'b1, -1, 1'b0);
        threshold = 11'd1020;
        frame(1, -1, 1'b0, -1, 1'b0);
        threshold = 11'd1019;
        frame(1, -1, 1'b1, 1020, 1'b0);
        frame(1, -1, 1'b0, -1, 1'b0);
        threshold = 11'd100;
        frame(1, -1, 1'b1, -1, 1'b1);
        frame(1, -1, 1'b1, -1, 1'b0);
        frame(1, 2, 1'b1, -1, 1'b0);

        repeat (5) drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk_pixel);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected outputs never checked, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_edge_detect.md
SOBEL_EDGE_DETECT -- requirements
Module: sobel_edge_detect

Interface
REQ-001 Parameter H_ACTIVE, default 640: maximum active pixels per line and line-buffer depth.
REQ-002 Parameter LATENCY, fixed at 3: pipeline delay in clk_pixel cycles, exposed for benches only.
REQ-003 Port clk_pixel, input, 1 bit: the single pixel clock; all logic is on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1 bit: in_gray carries a pixel this cycle.
REQ-006 Port in_hsync, input, 1 bit: high for the whole active line, including its last pixel.
REQ-007 Port in_vsync, input, 1 bit: high for the whole active frame, including its last pixel.
REQ-008 Port in_gray, input, 8 bits: unsigned grayscale pixel.
REQ-009 Port threshold, input, 11 bits: edge magnitude threshold, quasi-static.
REQ-010 Port valid, output, 1 bit: in_valid delayed by LATENCY.
REQ-011 Port hsync, output, 1 bit: in_hsync delayed by LATENCY.
REQ-012 Port vsync, output, 1 bit: in_vsync delayed by LATENCY.
REQ-013 Port sobel, output, 1 bit: binary edge pixel; these four outputs feed image_eth_formatter directly.

Function
REQ-014 Each output valid/hsync/vsync SHALL equal its input exactly LATENCY = 3 cycles earlier; all gaps SHALL be preserved cycle for cycle, so the 3-idle-cycle inter-line gap required by the formatter is kept.
REQ-015 Column counter col:
- resets to 0 when in_hsync is low;
- increments on each in_valid while in_hsync is high;
- saturates at H_ACTIVE.
REQ-016 Row counter row:
- resets to 0 when in_vsync is low;
- increments on each in_hsync falling edge while in_vsync is high;
- saturates at 3.
REQ-017 Line buffers: two line buffers of H_ACTIVE x 8 bits (row-1 and row-2) are read and written at address col on each in_valid with col < H_ACTIVE.
- The pixel from the row-1 buffer is moved into the row-2 buffer.
- in_gray is written into the row-1 buffer.
REQ-018 3x3 window: a 3x3 window register p[r][c] (r, c = 0..2; row 2 and column 2 are newest) shifts only on in_valid.
REQ-019 Gradients, computed as 11-bit signed values:
- Gx = (p02 + 2·p12 + p22) − (p00 + 2·p10 + p20);
- Gy = (p20 + 2·p21 + p22) − (p00 + 2·p01 + p02).
REQ-020 Magnitude mag = |Gx| + |Gy|, computed as 11-bit unsigned (maximum 2040, no overflow); sobel = 1 iff mag > threshold_latched (strictly greater than).
REQ-021 Border rule: sobel SHALL be 0 for any pixel with row < 2 or col < 2, for col ≥ H_ACTIVE, and whenever valid is 0.
- The output is therefore aligned to the window's bottom-right pixel, i.e. a one-pixel spatial shift.
REQ-022 threshold SHALL be latched into threshold_latched on every in_vsync rising edge; changes made mid-frame take effect at the next frame.
REQ-023 Pipeline stages:
- Stage 1: window/buffer update.
- Stage 2: Gx/Gy.
- Stage 3: magnitude compare into the sobel register.
- The sync/valid delay line SHALL be matched to these stages.
REQ-024 Simultaneous in_hsync fall with a final in_valid: the final pixel SHALL be processed before row increments.

Reset
REQ-025 While rst_n is low, SHALL hold the following at 0 immediately (asynchronous): valid, hsync, vsync, sobel, both counters, the delay line, the window registers and the frame_armed flag.
REQ-026 threshold_latched SHALL reset to 11'h7FF, so no edges are reported before the first latch.
REQ-027 After reset release, sobel SHALL be forced to 0 until the first in_vsync rising edge sets frame_armed; sync/valid delays run normally.
REQ-028 Line-buffer contents need not be reset; the border rule masks stale data.

Structure
REQ-029 A shared package SHALL hold:
- the gradient width (11) and magnitude width (11);
- LATENCY = 3;
- the Sobel kernel weights (1, 2, 1).
REQ-030 One sub-module, sobel_line_buffer (one instance per line, inferred simple dual-port RAM, 8 bits wide, depth H_ACTIVE, read-before-write at the same address), SHALL be used; all other logic stays in the top module.

Verification
REQ-031 Uniform frame (H_ACTIVE=16, 4 lines of 16 pixels, in_gray = 100, threshold = 50) -> sobel = 0 everywhere; valid/hsync/vsync equal the inputs delayed by exactly 3 cycles.
REQ-032 Vertical edge (columns 0–7 = 0, columns 8–15 = 255, threshold = 100) -> on rows 2–3, sobel = 1 only at col 8 and col 9 (mag = 1020); 0 everywhere else.
REQ-033 Horizontal edge (rows 0–1 = 0, rows 2–3 = 200, threshold = 100) -> sobel = 1 at rows 2–3 for cols 2–15 (mag = 800); rows 0–1 are all 0.
REQ-034 Threshold boundary using the REQ-032 edge (mag = 1020):
- threshold = 1020 -> sobel = 0;
- threshold = 1019 latched for the next frame -> sobel = 1;
- a threshold change made mid-frame has no effect until the next in_vsync rise.
REQ-035 Reset mid-frame: rst_n pulled low at row 2, col 5 -> all outputs are 0 within the same cycle; after release, sobel stays 0 through the end of that frame and behaves normally from the next frame.
REQ-036 Overlong line: a 20-pixel line with H_ACTIVE = 16 -> pixels 16–19 give sobel = 0 and no buffer write; the next line's results match REQ-032.
